// File: rtl/pad_counter_pkg.sv
// Shared definitions for the keypad-driven hex counter.
//   key_state_e : debounce/press FSM states
//   key_e       : decoded key codes (UP, CLEAR, DOWN, NONE)
//   SEG_TABLE   : hex digit -> active-low abcdefg glyph
//   decode_pad  : column levels -> key, priority up > clear > down
package pad_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_DEB,
    ST_HELD,
    ST_REL_DEB
  } key_state_e;

  typedef enum logic [1:0] {
    KEY_UP,
    KEY_CLEAR,
    KEY_DOWN,
    KEY_NONE
  } key_e;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // pad[0] = up (*), pad[1] = clear (0), pad[2] = down (#)
  function automatic key_e decode_pad(input logic [0:2] pad);
    if (pad[0])      return KEY_UP;
    else if (pad[1]) return KEY_CLEAR;
    else if (pad[2]) return KEY_DOWN;
    else             return KEY_NONE;
  endfunction

endpackage

// File: rtl/ssd_scan.sv
// Seven-segment scan multiplexer: one digit enabled per scan tick.
//   clk, rst_n : system clock, async active-low reset
//   tick       : one-cycle scan strobe
//   value      : hex value shown, digit 0 in value[3:0]
//   dig        : active-low digit enables, digit i on dig[7-i]
//   ssd        : active-low segments {a..g, dp}, dp held off
module ssd_scan
  import pad_counter_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic [4*DIGITS-1:0]   value,
  output logic [7:0]            dig,
  output logic [7:0]            ssd
);

  localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);

  logic [2:0]  idx_q, idx_d;
  logic [7:0]  dig_q, dig_d;
  logic [7:0]  ssd_q, ssd_d;
  logic [31:0] val_ext;
  logic [3:0]  nib;

  // Digit enable and glyph are both computed from the next index so they
  // land in the same register update.
  always_comb begin
    val_ext = 32'(value);
    idx_d   = idx_q;
    dig_d   = dig_q;
    ssd_d   = ssd_q;
    nib     = 4'd0;
    if (tick) begin
      idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
      nib   = val_ext[{idx_d, 2'b00} +: 4];
      dig_d = ~(8'h80 >> idx_d);
      ssd_d = {SEG_TABLE[nib], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 3'd0;
      dig_q <= 8'h7F;
      ssd_q <= {SEG_TABLE[0], 1'b1};
    end else begin
      idx_q <= idx_d;
      dig_q <= dig_d;
      ssd_q <= ssd_d;
    end
  end

  assign dig = dig_q;
  assign ssd = ssd_q;

endmodule

// File: rtl/multi_digit_pad_counter.sv
// Keypad-driven up/down/clear hex counter with multiplexed 7-seg display.
//   clk, rst_n   : system clock, async active-low reset
//   pad          : keypad column levels, active-high {up, clear, down}
//   pad_pos_out  : keypad row drive, constant 1
//   dig, ssd     : active-low digit enables / segments (from ssd_scan)
//   count        : current counter value
//
// state        | meaning
// ST_IDLE      | no key, waiting for a press
// ST_PRESS_DEB | candidate key seen, counting stable ticks
// ST_HELD      | press accepted and acted on, waiting for release
// ST_REL_DEB   | no key seen, counting stable release ticks
module multi_digit_pad_counter
  import pad_counter_pkg::*;
#(
  parameter int SCAN_DIV  = 208_334,
  parameter int DIGITS    = 4,
  parameter int DEB_TICKS = 4,
  parameter int WRAP      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [0:2]            pad,
  output logic                  pad_pos_out,
  output logic [7:0]            dig,
  output logic [7:0]            ssd,
  output logic [4*DIGITS-1:0]   count
);

  localparam int               CW       = 4 * DIGITS;
  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_LAST = 4'(DEB_TICKS);
  localparam logic [CW-1:0]    CNT_MAX  = '1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  key_state_e       state_q, state_d;
  key_e             key, cand_q, cand_d;
  logic [3:0]       deb_q, deb_d;
  logic             fire;
  logic [CW-1:0]    count_q, count_d;

  assign tick = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;
  assign key = decode_pad(pad);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    deb_d   = deb_q;
    fire    = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (key != KEY_NONE) begin
            cand_d = key;
            deb_d  = 4'd1;
            if (deb_d == DEB_LAST) begin
              fire    = 1'b1;
              state_d = ST_HELD;
            end else begin
              state_d = ST_PRESS_DEB;
            end
          end
        end
        ST_PRESS_DEB: begin
          if (key == cand_q) begin
            deb_d = deb_q + 4'd1;
            if (deb_d == DEB_LAST) begin
              fire    = 1'b1;
              state_d = ST_HELD;
            end
          end else begin
            deb_d   = 4'd0;
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (key == KEY_NONE) begin
            deb_d   = 4'd1;
            state_d = (deb_d == DEB_LAST) ? ST_IDLE : ST_REL_DEB;
          end
        end
        ST_REL_DEB: begin
          if (key == KEY_NONE) begin
            deb_d = deb_q + 4'd1;
            if (deb_d == DEB_LAST) state_d = ST_IDLE;
          end else begin
            deb_d   = 4'd0;
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // On a fire, the current key equals the debounced candidate.
  always_comb begin
    count_d = count_q;
    if (fire) begin
      case (key)
        KEY_UP:    if (count_q != CNT_MAX || WRAP != 0) count_d = count_q + 1'b1;
        KEY_DOWN:  if (count_q != '0 || WRAP != 0)      count_d = count_q - 1'b1;
        KEY_CLEAR: count_d = '0;
        default:   count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      state_q <= ST_IDLE;
      cand_q  <= KEY_NONE;
      deb_q   <= 4'd0;
      count_q <= '0;
    end else begin
      div_q   <= div_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      deb_q   <= deb_d;
      count_q <= count_d;
    end
  end

  ssd_scan #(
    .DIGITS(DIGITS)
  ) u_scan (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .value(count_q),
    .dig  (dig),
    .ssd  (ssd)
  );

  assign pad_pos_out = 1'b1;
  assign count       = count_q;

endmodule

// File: tb/tb_multi_digit_pad_counter.sv
module tb_multi_digit_pad_counter;

  localparam logic [0:2] P_UP    = 3'b100;
  localparam logic [0:2] P_CLEAR = 3'b010;
  localparam logic [0:2] P_DOWN  = 3'b001;
  localparam logic [0:2] P_BOTH  = 3'b101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:2] pad_s, pad_w;
  logic       ppo_s, ppo_w;
  logic [7:0] dig_s, dig_w, ssd_s, ssd_w, count_s, count_w;

  always #5 clk = ~clk;

  multi_digit_pad_counter #(
    .SCAN_DIV(4), .DIGITS(2), .DEB_TICKS(2), .WRAP(0)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pad(pad_s), .pad_pos_out(ppo_s),
    .dig(dig_s), .ssd(ssd_s), .count(count_s)
  );

  multi_digit_pad_counter #(
    .SCAN_DIV(4), .DIGITS(2), .DEB_TICKS(2), .WRAP(1)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .pad(pad_w), .pad_pos_out(ppo_w),
    .dig(dig_w), .ssd(ssd_w), .count(count_w)
  );

  int checks   = 0;
  int failures = 0;
  int edge_cnt;

  typedef struct {
    logic [7:0] v;
    int         e;   // posedge number the change must appear on, -1 = any
  } exp_t;

  exp_t       q_s[$];
  exp_t       q_w[$];
  logic [7:0] cur_s = 8'h00;
  logic [7:0] cur_w = 8'h00;
  logic [7:0] prev_s = 8'h00;
  logic [7:0] prev_w = 8'h00;

  // Posedges since reset release; divider ticks on every 4th edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitors: every change of count is an output event matched to the queue.
  always @(negedge clk) begin
    exp_t x;
    if (count_s !== prev_s) begin
      checks++;
      if (q_s.size() == 0) begin
        failures++;
        $display("FAIL sat_unexpected: count %h (was %h) with nothing expected", count_s, prev_s);
      end else begin
        x = q_s.pop_front();
        if (count_s !== x.v || (x.e >= 0 && edge_cnt != x.e)) begin
          failures++;
          $display("FAIL sat_count: got %h at edge %0d expected %h at edge %0d",
                   count_s, edge_cnt, x.v, x.e);
        end
      end
      prev_s = count_s;
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (count_w !== prev_w) begin
      checks++;
      if (q_w.size() == 0) begin
        failures++;
        $display("FAIL wrap_unexpected: count %h (was %h) with nothing expected", count_w, prev_w);
      end else begin
        x = q_w.pop_front();
        if (count_w !== x.v || (x.e >= 0 && edge_cnt != x.e)) begin
          failures++;
          $display("FAIL wrap_count: got %h at edge %0d expected %h at edge %0d",
                   count_w, edge_cnt, x.v, x.e);
        end
      end
      prev_w = count_w;
    end
  end

  // Returns 1 ns after the next tick edge.
  task automatic next_tick();
    do begin
      @(posedge clk);
      #1;
    end while (edge_cnt % 4 != 0);
  endtask

  // Press starts just after a tick edge T0; with DEB_TICKS=2 the action
  // lands on the edge of T0+2 ticks = base+8 posedges.
  task automatic press(input bit w, input logic [0:2] p, input int hold, input logic [7:0] exp);
    int         base;
    logic [7:0] cur;
    next_tick();
    base = edge_cnt;
    cur  = w ? cur_w : cur_s;
    if (exp != cur) begin
      if (w) begin q_w.push_back('{v: exp, e: base + 8}); cur_w = exp; end
      else   begin q_s.push_back('{v: exp, e: base + 8}); cur_s = exp; end
    end
    if (w) pad_w = p; else pad_s = p;
    repeat (hold) next_tick();
    pad_w = 3'b000;
    pad_s = 3'b000;
    repeat (2) next_tick();
    if (exp == cur) chk(w ? "wrap_hold" : "sat_hold", w ? count_w : count_s, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pad_s = 3'b000;
    pad_w = 3'b000;
    rst_n = 1'b0;
    #13;
    chk("rst_count_s", count_s, 8'h00);
    chk("rst_count_w", count_w, 8'h00);
    chk("rst_dig",     dig_s,   8'h7F);
    chk("rst_ssd",     ssd_s,   8'b0000001_1);
    chk("pad_pos_out", {ppo_s, ppo_w}, 2'b11);
    #10;
    rst_n = 1'b1;

    press(0, P_UP, 3, 8'h01);                   // held 3 ticks -> one action
    press(0, P_UP, 1, 8'h01);                   // bounce -> nothing
    for (int i = 2; i <= 255; i++) press(0, P_UP, 2, 8'(i));
    press(0, P_UP,    2, 8'hFF);                // saturate high
    press(0, P_CLEAR, 2, 8'h00);
    press(0, P_DOWN,  2, 8'h00);                // saturate low

    press(1, P_DOWN, 2, 8'hFF);                 // wrap low
    press(1, P_UP,   2, 8'h00);                 // wrap high

    for (int i = 1; i <= 5; i++) press(0, P_UP, 2, 8'(i));
    press(0, P_BOTH,  2, 8'h06);                // up wins over down
    press(0, P_CLEAR, 2, 8'h00);

    for (int i = 1; i <= 163; i++) press(0, P_UP, 2, 8'(i));   // -> A3
    chk("sat_A3", count_s, 8'hA3);
    for (int k = 0; k < 4; k++) begin
      next_tick();
      if ((edge_cnt / 4) % 2 == 1) begin
        chk("scan_dig_hi", dig_s, 8'hBF);
        chk("scan_ssd_hi", ssd_s, 8'b0001000_1);
      end else begin
        chk("scan_dig_lo", dig_s, 8'h7F);
        chk("scan_ssd_lo", ssd_s, 8'b0000110_1);
      end
      chk("scan_ssd_zero", ssd_w, 8'b0000001_1);
    end

    for (int i = 1; i <= 7; i++) press(1, P_UP, 2, 8'(i));     // -> 07

    // Reset in the middle of a press debounce.
    next_tick();
    pad_w = P_UP;
    next_tick();                                // now in PRESS_DEB
    #2;
    q_s.push_back('{v: 8'h00, e: -1});
    q_w.push_back('{v: 8'h00, e: -1});
    cur_s = 8'h00;
    cur_w = 8'h00;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count_w", count_w, 8'h00);
    chk("mid_rst_count_s", count_s, 8'h00);
    chk("mid_rst_dig",     dig_w,   8'h7F);
    chk("mid_rst_ssd",     ssd_w,   8'b0000001_1);
    #10;
    q_w.push_back('{v: 8'h01, e: 8});
    cur_w = 8'h01;
    rst_n = 1'b1;
    next_tick();
    chk("post_rst_no_early", count_w, 8'h00);
    next_tick();
    chk("post_rst_action", count_w, 8'h01);
    pad_w = 3'b000;
    repeat (3) next_tick();

    chk("queue_s_empty", 32'(q_s.size()), 32'd0);
    chk("queue_w_empty", 32'(q_w.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_digit_pad_counter.md
MULTI_DIGIT_PAD_COUNTER -- requirements
Module: multi_digit_pad_counter

Interface
REQ-001 Parameter SCAN_DIV, default 208_334, is the clk cycles per scan tick (480 Hz at 100 MHz); legal range 2 and above.
REQ-002 Parameter DIGITS, default 4, is the number of hex digits counted and displayed; legal range 1..8.
REQ-003 Parameter DEB_TICKS, default 4, is the number of consecutive ticks a key level must be stable before it is accepted; legal range 1..15.
REQ-004 Parameter WRAP, default 0, selects the count limit mode: 0 saturates, 1 wraps modulo 2^(4*DIGITS).
REQ-005 Port clk, input, 1 bit, is the single system clock; all state is clocked on its rising edge.
REQ-006 Port rst_n, input, 1 bit, is an asynchronous active-low reset.
REQ-007 Port pad, input [0:2], is the keypad column levels, active-high: pad[0] = up (*), pad[1] = clear (0), pad[2] = down (#).
REQ-008 Port pad_pos_out, output, 1 bit, is the keypad row drive and is held constant at 1.
REQ-009 Port dig, output [7:0], is the active-low digit enables; digit i (i = 0 is least significant) drives dig[7-i]; all other bits stay 1.
REQ-010 Port ssd, output [7:0], is the active-low segments: ssd[7:1] = a..g and ssd[0] = dp, with dp always 1.
REQ-011 Port count, output [4*DIGITS-1:0], is the current counter value.

Function
REQ-012 A free-running divider shall produce a one-cycle tick when it reaches SCAN_DIV-1, then return to 0; no derived clocks are permitted.
REQ-013 The key decoder shall map pad to a key with priority up > clear > down; no bit set decodes as NONE.
REQ-014 The key FSM has states IDLE, PRESS_DEB, HELD and REL_DEB, and advances only on tick.
REQ-015 IDLE -> PRESS_DEB when key != NONE; the candidate key and deb_cnt = 1 are latched.
REQ-016 In PRESS_DEB, if key equals the candidate, deb_cnt increments; on reaching DEB_TICKS the action is issued and the FSM goes to HELD. If key differs from the candidate, the FSM returns to IDLE.
REQ-017 HELD -> REL_DEB when key == NONE; any key change while in HELD is ignored.
REQ-018 In REL_DEB, NONE stable for DEB_TICKS ticks returns the FSM to IDLE; any key seen during REL_DEB returns it to HELD with no action.
REQ-019 Exactly one action is issued per accepted press; there is no auto-repeat.
REQ-020 Action up: count+1; at the maximum it holds (WRAP=0) or goes to 0 (WRAP=1).
REQ-021 Action down: count-1; at 0 it holds (WRAP=0) or goes to the maximum (WRAP=1).
REQ-022 Action clear: count <= 0 regardless of WRAP.
REQ-023 count shall update on the clk edge after the tick that completes the debounce (latency of 1 clk).
REQ-024 The scan index shall advance by one per tick through 0..DIGITS-1 and wrap to 0.
REQ-025 dig shall enable only the indexed digit, and ssd shall show the hex glyph of count[4i+3:4i] for that digit.
REQ-026 dig and ssd shall be registered and change together, one clk after the tick.
REQ-027 Glyphs for 0..F (abcdefg, active-low): 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.

Reset
REQ-028 While rst_n = 0: divider = 0, FSM = IDLE, deb_cnt = 0, count = 0, scan index = 0, dig = 0111_1111, ssd = 0000001_1.
REQ-029 Reset asserted mid-press shall abort the press with no action; after release of reset the FSM waits in IDLE for a fresh press.

Structure
REQ-030 Shared package pad_counter_pkg shall hold the FSM state enum, key codes (UP, CLEAR, DOWN, NONE) and the hex-to-segment constant table.
REQ-031 Scan multiplexing and glyph decode shall be a sub-module ssd_scan (parameter DIGITS; inputs clk, rst_n, tick, value; outputs dig, ssd).

Verification (SCAN_DIV=4, DEB_TICKS=2, DIGITS=2)
REQ-032 Hold up for 3 ticks, then release -> count goes 00 -> 01 exactly once, 1 clk after the 2nd tick.
REQ-033 Pulse up for 1 tick only (bounce) -> count stays 00.
REQ-034 WRAP=0: count=FF, press up -> FF; count=00, press down -> 00. WRAP=1: FF + up -> 00, 00 + down -> FF.
REQ-035 pad=101 (up and down together) while count=05 -> 06; then press clear -> 00.
REQ-036 count=A3 -> dig alternates 0111_1111 / 1011_1111, with ssd 0000110_1 / 0001000_1 respectively, one digit per tick.
REQ-037 Assert rst_n low during PRESS_DEB with count=07 -> all reset values at once; holding the key after release of reset yields one action only after DEB_TICKS further ticks.
